piece_dropper: RTL and testbench

Write-side partner of the victory checker. It accepts a move request (column and player), scans the column bottom-up for the first empty cell, and writes the piece into the board memory. It then starts the victory checker with the placed row/column, waits for it to finish, and reports the result. On reset it also sweeps the board memory to empty.

---
 rtl/piece_dropper_pkg.sv | 31 +++
 rtl/piece_dropper.sv | 182 ++++++++++++++++++
 tb/tb_piece_dropper.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piece_dropper_pkg.sv
// Shared encodings for the piece dropper: cell values, result codes, FSM states
// and default board geometry.
package piece_dropper_pkg;

    localparam int NUM_ROWS_DEFAULT = 6;
    localparam int NUM_COLS_DEFAULT = 7;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    localparam logic [1:0] RES_OK        = 2'b00;
    localparam logic [1:0] RES_COL_FULL  = 2'b01;
    localparam logic [1:0] RES_INVALID   = 2'b10;
    localparam logic [1:0] RES_GAME_OVER = 2'b11;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_SCAN,
        ST_WRITE,
        ST_CHK_START,
        ST_CHK_WAIT,
        ST_DONE
    } state_t;

    function automatic logic valid_player(input logic [1:0] player);
        return (player == CELL_P1) || (player == CELL_P2);
    endfunction

endpackage

// File: rtl/piece_dropper.sv
// Drops a piece into the lowest empty cell of a column, runs the victory
// checker on the placed cell and reports the outcome; sweeps the board on reset.
module piece_dropper
    import piece_dropper_pkg::*;
#(
    parameter int NUM_ROWS = NUM_ROWS_DEFAULT,
    parameter int NUM_COLS = NUM_COLS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_valid,
    output logic       move_ready,
    input  logic [2:0] req_col,
    input  logic [1:0] req_player,
    output logic [2:0] read_row,
    output logic [2:0] read_col,
    input  logic [1:0] data_in,
    output logic       write_en,
    output logic [2:0] write_row,
    output logic [2:0] write_col,
    output logic [1:0] write_data,
    output logic       check_start,
    output logic [2:0] move_row,
    output logic [2:0] move_col,
    input  logic       check_done,
    input  logic [1:0] winner,
    output logic       move_done,
    output logic [1:0] move_result,
    output logic       game_over,
    output logic       draw
);

    localparam logic [2:0] LAST_ROW   = 3'(NUM_ROWS - 1);
    localparam logic [2:0] LAST_COL   = 3'(NUM_COLS - 1);
    localparam logic [3:0] COL_LIMIT  = 4'(NUM_COLS);
    localparam logic [6:0] CELL_COUNT = 7'(NUM_ROWS * NUM_COLS);

    state_t     state_reg, state_next;
    logic [2:0] scan_row_reg, scan_row_next;
    logic [2:0] col_reg, col_next;
    logic [1:0] player_reg, player_next;
    logic [2:0] wr_row_reg, wr_row_next;
    logic [2:0] wr_col_reg, wr_col_next;
    logic [2:0] move_row_reg, move_row_next;
    logic [2:0] move_col_reg, move_col_next;
    logic [6:0] count_reg, count_next;
    logic [1:0] result_reg, result_next;
    logic       game_over_reg, game_over_next;
    logic       draw_reg, draw_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_CLEAR;
            scan_row_reg  <= '0;
            col_reg       <= '0;
            player_reg    <= '0;
            wr_row_reg    <= '0;
            wr_col_reg    <= '0;
            move_row_reg  <= '0;
            move_col_reg  <= '0;
            count_reg     <= '0;
            result_reg    <= '0;
            game_over_reg <= 1'b0;
            draw_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            scan_row_reg  <= scan_row_next;
            col_reg       <= col_next;
            player_reg    <= player_next;
            wr_row_reg    <= wr_row_next;
            wr_col_reg    <= wr_col_next;
            move_row_reg  <= move_row_next;
            move_col_reg  <= move_col_next;
            count_reg     <= count_next;
            result_reg    <= result_next;
            game_over_reg <= game_over_next;
            draw_reg      <= draw_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        scan_row_next  = scan_row_reg;
        col_next       = col_reg;
        player_next    = player_reg;
        wr_row_next    = wr_row_reg;
        wr_col_next    = wr_col_reg;
        move_row_next  = move_row_reg;
        move_col_next  = move_col_reg;
        count_next     = count_reg;
        result_next    = result_reg;
        game_over_next = game_over_reg;
        draw_next      = draw_reg;

        case (state_reg)
            // The write address registers double as the sweep counter.
            ST_CLEAR: begin
                if (wr_col_reg == LAST_COL) begin
                    if (wr_row_reg == LAST_ROW) begin
                        state_next = ST_IDLE;
                    end else begin
                        wr_col_next = '0;
                        wr_row_next = wr_row_reg + 3'd1;
                    end
                end else begin
                    wr_col_next = wr_col_reg + 3'd1;
                end
            end
            ST_IDLE: begin
                if (move_valid) begin
                    if (game_over_reg || draw_reg) begin
                        result_next = RES_GAME_OVER;
                        state_next  = ST_DONE;
                    end else if (({1'b0, req_col} >= COL_LIMIT) || !valid_player(req_player)) begin
                        result_next = RES_INVALID;
                        state_next  = ST_DONE;
                    end else begin
                        col_next      = req_col;
                        player_next   = req_player;
                        scan_row_next = '0;
                        state_next    = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (data_in == CELL_EMPTY) begin
                    move_row_next = scan_row_reg;
                    move_col_next = col_reg;
                    wr_row_next   = scan_row_reg;
                    wr_col_next   = col_reg;
                    state_next    = ST_WRITE;
                end else if (scan_row_reg == LAST_ROW) begin
                    result_next = RES_COL_FULL;
                    state_next  = ST_DONE;
                end else begin
                    scan_row_next = scan_row_reg + 3'd1;
                end
            end
            ST_WRITE: begin
                count_next = count_reg + 7'd1;
                state_next = ST_CHK_START;
            end
            ST_CHK_START: begin
                state_next = ST_CHK_WAIT;
            end
            ST_CHK_WAIT: begin
                if (check_done) begin
                    if (winner != CELL_EMPTY) begin
                        game_over_next = 1'b1;
                    end else if (count_reg == CELL_COUNT) begin
                        draw_next = 1'b1;
                    end
                    result_next = RES_OK;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    // Strobes are masked while rst is high so nothing fires in the reset cycle.
    assign move_ready  = (state_reg == ST_IDLE) && !rst;
    assign write_en    = ((state_reg == ST_CLEAR) || (state_reg == ST_WRITE)) && !rst;
    assign check_start = (state_reg == ST_CHK_START) && !rst;
    assign move_done   = (state_reg == ST_DONE) && !rst;
    assign write_data  = (state_reg == ST_WRITE) ? player_reg : CELL_EMPTY;
    assign read_row    = scan_row_reg;
    assign read_col    = col_reg;
    assign write_row   = wr_row_reg;
    assign write_col   = wr_col_reg;
    assign move_row    = move_row_reg;
    assign move_col    = move_col_reg;
    assign move_result = result_reg;
    assign game_over   = game_over_reg;
    assign draw        = draw_reg;

endmodule

// File: tb/tb_piece_dropper.sv
// Bench for piece_dropper: board memory and victory checker models, a result
// scoreboard queue and one task per scenario.
module tb_piece_dropper;

    localparam int NR    = 6;
    localparam int NC    = 7;
    localparam int CELLS = NR * NC;

    localparam logic [1:0] R_OK        = 2'b00;
    localparam logic [1:0] R_COL_FULL  = 2'b01;
    localparam logic [1:0] R_INVALID   = 2'b10;
    localparam logic [1:0] R_GAME_OVER = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       move_valid = 1'b0;
    logic       move_ready;
    logic [2:0] req_col = 3'd0;
    logic [1:0] req_player = 2'd0;
    logic [2:0] read_row, read_col;
    logic [1:0] data_in;
    logic       write_en;
    logic [2:0] write_row, write_col;
    logic [1:0] write_data;
    logic       check_start;
    logic [2:0] move_row, move_col;
    logic       check_done;
    logic [1:0] winner = 2'b00;
    logic       move_done;
    logic [1:0] move_result;
    logic       game_over, draw;

    int total = 0;
    int bad = 0;

    logic [1:0] board [8][8];
    logic [1:0] exp_q [$];
    int         chk_lat = 2;
    int         chk_cnt;

    int model_height [8];
    int model_moves;
    bit model_over;
    bit model_draw;

    always #5 clk = ~clk;

    piece_dropper #(.NUM_ROWS(NR), .NUM_COLS(NC)) dut (
        .clk(clk), .rst(rst),
        .move_valid(move_valid), .move_ready(move_ready),
        .req_col(req_col), .req_player(req_player),
        .read_row(read_row), .read_col(read_col), .data_in(data_in),
        .write_en(write_en), .write_row(write_row), .write_col(write_col),
        .write_data(write_data),
        .check_start(check_start), .move_row(move_row), .move_col(move_col),
        .check_done(check_done), .winner(winner),
        .move_done(move_done), .move_result(move_result),
        .game_over(game_over), .draw(draw)
    );

    assign data_in = board[read_row][read_col];

    always @(posedge clk) begin
        if (write_en) board[write_row][write_col] <= write_data;
    end

    // Victory checker model: check_done pulses chk_lat edges after check_start.
    always @(posedge clk) begin
        if (rst) begin
            chk_cnt    <= 0;
            check_done <= 1'b0;
        end else if (check_start) begin
            chk_cnt    <= chk_lat;
            check_done <= 1'b0;
        end else if (chk_cnt > 0) begin
            chk_cnt    <= chk_cnt - 1;
            check_done <= (chk_cnt == 1);
        end else begin
            check_done <= 1'b0;
        end
    end

    task automatic apply_reset(input string tag);
        int nonzero;
        @(negedge clk);
        rst = 1'b1;
        winner = 2'b00;
        chk_lat = 2;
        repeat (2) @(negedge clk);
        total++;
        if ({move_ready, write_en, check_start, move_done, game_over, draw, move_result,
             write_row, write_col, write_data, read_row, read_col, move_row, move_col} !== 30'd0) begin
            bad++;
            $display("FAIL %s reset_outputs: ready=%b wen=%b cs=%b done=%b go=%b draw=%b res=%0d wr=(%0d,%0d) rd=(%0d,%0d) mv=(%0d,%0d), all required 0",
                     tag, move_ready, write_en, check_start, move_done, game_over, draw, move_result,
                     write_row, write_col, read_row, read_col, move_row, move_col);
        end
        for (int c = 0; c < 8; c++) model_height[c] = 0;
        model_moves = 0;
        model_over  = 1'b0;
        model_draw  = 1'b0;
        exp_q.delete();
        rst = 1'b0;
        #1;
        for (int i = 0; i < CELLS; i++) begin
            total++;
            if (write_en !== 1'b1 || write_row !== 3'(i / NC) || write_col !== 3'(i % NC) ||
                write_data !== 2'b00 || move_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s sweep_cycle%0d: wen=%b addr=(%0d,%0d) data=%0d ready=%b, required wen=1 addr=(%0d,%0d) data=0 ready=0",
                         tag, i + 1, write_en, write_row, write_col, write_data, move_ready, i / NC, i % NC);
            end
            @(negedge clk);
        end
        total++;
        if (move_ready !== 1'b1 || write_en !== 1'b0) begin
            bad++;
            $display("FAIL %s ready_after_sweep: ready=%b wen=%b, required ready=1 wen=0", tag, move_ready, write_en);
        end
        nonzero = 0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (board[r][c] !== 2'b00) nonzero++;
        total++;
        if (nonzero != 0) begin
            bad++;
            $display("FAIL %s board_empty: %0d non-empty cells, required 0", tag, nonzero);
        end
        $display("%s: reset and %0d-cell sweep done", tag, CELLS);
    endtask

    task automatic do_move(input string tag, input int col, input logic [1:0] player, input logic [1:0] win);
        logic [1:0] exp_res, got_res;
        int exp_row, exp_lat, cyc, wr_cnt, cs_cnt, hold_err;
        logic [2:0] wr_r, wr_c;
        logic [1:0] wr_d;
        bit done_seen;
        exp_row = -1;
        if (model_over || model_draw) exp_res = R_GAME_OVER;
        else if (col >= NC || !(player == 2'b01 || player == 2'b10)) exp_res = R_INVALID;
        else if (model_height[col] == NR) exp_res = R_COL_FULL;
        else begin
            exp_res = R_OK;
            exp_row = model_height[col];
        end
        exp_q.push_back(exp_res);
        case (exp_res)
            R_OK:       exp_lat = (exp_row + 1) + 1 + 1 + (chk_lat + 1) + 1;
            R_COL_FULL: exp_lat = NR + 1;
            default:    exp_lat = 1;
        endcase
        winner = win;

        cyc = 0;
        while (move_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (move_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_wait: move_ready=%b after %0d cycles, required 1", tag, move_ready, cyc);
        end
        move_valid = 1'b1;
        req_col    = 3'(col);
        req_player = player;
        @(posedge clk);
        #1 move_valid = 1'b0;

        cyc = 0; wr_cnt = 0; cs_cnt = 0; hold_err = 0; done_seen = 1'b0;
        wr_r = 3'd0; wr_c = 3'd0; wr_d = 2'd0;
        while (!done_seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (write_en === 1'b1) begin
                wr_cnt++;
                wr_r = write_row; wr_c = write_col; wr_d = write_data;
            end
            if (check_start === 1'b1) cs_cnt++;
            if (exp_res == R_OK && cyc > exp_row + 1 &&
                (move_row !== 3'(exp_row) || move_col !== 3'(col))) hold_err++;
            if (move_done === 1'b1) done_seen = 1'b1;
        end
        total++;
        if (!done_seen) begin
            bad++;
            $display("FAIL %s done_timeout: move_done=0 after %0d cycles, required a pulse", tag, cyc);
        end
        got_res = move_result;
        exp_res = exp_q.pop_front();
        total++;
        if (got_res !== exp_res) begin
            bad++;
            $display("FAIL %s result: got %0d, required %0d", tag, got_res, exp_res);
        end
        total++;
        if (cyc != exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d cycles, required %0d", tag, cyc, exp_lat);
        end
        total++;
        if (wr_cnt != ((exp_res == R_OK) ? 1 : 0) || cs_cnt != ((exp_res == R_OK) ? 1 : 0)) begin
            bad++;
            $display("FAIL %s strobes: writes=%0d check_starts=%0d, required %0d each",
                     tag, wr_cnt, cs_cnt, (exp_res == R_OK) ? 1 : 0);
        end
        if (exp_res == R_OK) begin
            total++;
            if (wr_r !== 3'(exp_row) || wr_c !== 3'(col) || wr_d !== player) begin
                bad++;
                $display("FAIL %s write: got (%0d,%0d)=%0d, required (%0d,%0d)=%0d",
                         tag, wr_r, wr_c, wr_d, exp_row, col, player);
            end
            total++;
            if (hold_err != 0) begin
                bad++;
                $display("FAIL %s move_pos_hold: %0d cycles off, required move_row=%0d move_col=%0d throughout",
                         tag, hold_err, exp_row, col);
            end
            model_height[col]++;
            model_moves++;
            if (win != 2'b00) model_over = 1'b1;
            else if (model_moves == CELLS) model_draw = 1'b1;
        end
        total++;
        if (game_over !== model_over || draw !== model_draw) begin
            bad++;
            $display("FAIL %s flags: game_over=%b draw=%b, required game_over=%b draw=%b",
                     tag, game_over, draw, model_over, model_draw);
        end
        @(negedge clk);
        total++;
        if (move_done !== 1'b0 || move_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s done_pulse: move_done=%b move_ready=%b a cycle later, required 0 and 1",
                     tag, move_done, move_ready);
        end
        $display("%s: col=%0d player=%0d result=%0d row=%0d cycles=%0d", tag, col, player, got_res, exp_row, cyc);
    endtask

    task automatic test_reset();
        apply_reset("test_reset");
    endtask

    task automatic test_drop_empty();
        do_move("drop_empty", 3, 2'b01, 2'b00);
    endtask

    task automatic test_stack();
        do_move("stack0", 2, 2'b01, 2'b00);
        do_move("stack1", 2, 2'b10, 2'b00);
        do_move("stack2", 2, 2'b01, 2'b00);
        do_move("stack3", 2, 2'b10, 2'b00);
        total++;
        if (board[3][2] !== 2'b10) begin
            bad++;
            $display("FAIL stack_cell: board(3,2)=%0d, required 2", board[3][2]);
        end
    endtask

    task automatic test_col_full();
        for (int i = 0; i < NR; i++) do_move("fill_col5", 5, (i % 2 == 0) ? 2'b01 : 2'b10, 2'b00);
        do_move("col_full", 5, 2'b01, 2'b00);
    endtask

    task automatic test_invalid();
        logic [2:0] rr, rc;
        rr = read_row;
        rc = read_col;
        do_move("invalid_col", 7, 2'b01, 2'b00);
        do_move("invalid_player", 1, 2'b11, 2'b00);
        total++;
        if (read_row !== rr || read_col !== rc) begin
            bad++;
            $display("FAIL invalid_read_addr: (%0d,%0d), required unchanged (%0d,%0d)", read_row, read_col, rr, rc);
        end
    endtask

    task automatic test_back_to_back();
        chk_lat = 1;
        do_move("b2b_lat1", 6, 2'b01, 2'b00);
        chk_lat = 5;
        do_move("b2b_lat5", 6, 2'b10, 2'b00);
        chk_lat = 2;
        do_move("b2b_lat2", 0, 2'b01, 2'b00);
    endtask

    task automatic test_game_over();
        do_move("winning_move", 4, 2'b01, 2'b01);
        do_move("after_win", 1, 2'b10, 2'b01);
    endtask

    task automatic test_reset_mid_check();
        int cyc;
        apply_reset("pre_mid_chk");
        chk_lat = 30;
        winner  = 2'b01;
        cyc = 0;
        while (move_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        move_valid = 1'b1;
        req_col    = 3'd4;
        req_player = 2'b10;
        @(posedge clk);
        #1 move_valid = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (board[0][4] !== 2'b10 || move_ready !== 1'b0 || check_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_chk_setup: cell(0,4)=%0d ready=%b check_done=%b, required 2, 0, 0",
                     board[0][4], move_ready, check_done);
        end
        apply_reset("reset_mid_chk");
    endtask

    task automatic test_draw();
        apply_reset("pre_draw");
        for (int i = 0; i < CELLS; i++)
            do_move("draw_fill", i / NR, (i % 2 == 0) ? 2'b01 : 2'b10, 2'b00);
        total++;
        if (draw !== 1'b1 || game_over !== 1'b0) begin
            bad++;
            $display("FAIL draw_flag: draw=%b game_over=%b, required 1 and 0", draw, game_over);
        end
        do_move("after_draw", 3, 2'b01, 2'b00);
    endtask

    initial begin
        test_reset();
        test_drop_empty();
        test_stack();
        test_col_full();
        test_invalid();
        test_back_to_back();
        test_game_over();
        test_reset_mid_check();
        test_draw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
